// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the register-file write path.
//   DATA_W / ADDR_W : default register width and register address width
//   WE_ACTIVE/IDLE  : levels of the active-low register-file write enable
//   wr_req_t        : one queued write (target address + data)
//   onehot_decode() : register address -> one-hot register select
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int DEPTH_W = 1 << ADDR_W;

    localparam logic WE_ACTIVE = 1'b0;
    localparam logic WE_IDLE   = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [DEPTH_W-1:0] onehot_decode(input logic [ADDR_W-1:0] addr);
        logic [DEPTH_W-1:0] sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/regfile_wr_seq_if.sv
// -----------------------------------------------------------------------------
// regfile_wr_seq_if
// Bundles the producer handshake and the register-file write-port bus of the
// write sequencer.
//   in_valid/in_addr/in_data : per-lane producer requests
//   in_ready                 : all lanes accepted this cycle
//   wstall                   : register-file owner blocks draining
//   waddr/we_/wdata          : register-file write ports (we_ active-low)
//   pend                     : per-register "write queued" bitmap
//   count                    : occupied queue entries
// master = producer / register-file side, slave = sequencer.
// -----------------------------------------------------------------------------
interface regfile_wr_seq_if
    import regfile_pkg::*;
#(
    parameter int DATA   = DATA_W,
    parameter int ADDR   = ADDR_W,
    parameter int IN     = 4,
    parameter int WRITE  = 2,
    parameter int QDEPTH = 8
);
    localparam int DEPTH = 1 << ADDR;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [IN-1:0]                in_valid;
    logic [IN-1:0][ADDR-1:0]      in_addr;
    logic [IN-1:0][DATA-1:0]      in_data;
    logic                         in_ready;
    logic                         wstall;
    logic [WRITE-1:0][ADDR-1:0]   waddr;
    logic [WRITE-1:0]             we_;
    logic [WRITE-1:0][DATA-1:0]   wdata;
    logic [DEPTH-1:0]             pend;
    logic [CNT_W-1:0]             count;

    modport master (
        output in_valid, in_addr, in_data, wstall,
        input  in_ready, waddr, we_, wdata, pend, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, wstall,
        output in_ready, waddr, we_, wdata, pend, count
    );

endinterface

// File: rtl/regfile_wr_seq_lane_compact.sv
// -----------------------------------------------------------------------------
// lane_compact
// Packs the kept lanes of a multi-lane request vector into the low slots of
// the output, preserving ascending lane order, and reports how many were kept.
// Purely combinational.
//   in_valid : per-lane valid
//   in_req   : per-lane request
//   out_req  : kept requests in slots 0..out_cnt-1, zero above
//   out_cnt  : number of kept lanes
// With ZERO_REG set, lanes targeting address 0 are dropped (not kept).
// -----------------------------------------------------------------------------
module lane_compact
    import regfile_pkg::*;
#(
    parameter int IN       = 4,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic [IN-1:0]              in_valid,
    input  wr_req_t [IN-1:0]           in_req,
    output wr_req_t [IN-1:0]           out_req,
    output logic [$clog2(IN+1)-1:0]    out_cnt
);

    localparam int CNT_W = $clog2(IN + 1);

    logic [IN-1:0] keep;
    int            rank;

    // rank is the number of kept lanes below lane i, i.e. its output slot.
    // The inner loop uses constant slot indices so no variable-index write
    // is needed.
    always_comb begin
        out_req = '0;
        keep    = '0;
        rank    = 0;
        for (int i = 0; i < IN; i++) begin
            keep[i] = in_valid[i] && !(ZERO_REG && (in_req[i].addr == '0));
            if (keep[i]) begin
                for (int o = 0; o < IN; o++) begin
                    if (o == rank) begin
                        out_req[o] = in_req[i];
                    end
                end
                rank = rank + 1;
            end
        end
        out_cnt = CNT_W'(rank);
    end

endmodule

// File: rtl/regfile_wr_seq.sv
// -----------------------------------------------------------------------------
// regfile_wr_seq
// Write-side sequencer for the multi-port register file. Accepts up to IN
// writes per cycle (all-or-nothing), queues them in order in a circular
// buffer and drains up to WRITE per cycle onto the active-low write ports,
// oldest entry on port 0.
//   clk   : clock
//   reset : asynchronous, active-high reset (control state only)
//   bus   : regfile_wr_seq_if.slave (producer handshake, write ports,
//           pend bitmap, occupancy count)
// DATA/ADDR must match the regfile_pkg widths: queue entries are wr_req_t.
// -----------------------------------------------------------------------------
module regfile_wr_seq
    import regfile_pkg::*;
#(
    parameter int DATA     = DATA_W,
    parameter int ADDR     = ADDR_W,
    parameter int IN       = 4,
    parameter int WRITE    = 2,
    parameter int QDEPTH   = 8,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    regfile_wr_seq_if.slave  bus
);

    localparam int PTR_W    = $clog2(QDEPTH);
    localparam int CNT_W    = $clog2(QDEPTH + 1);
    localparam int IN_CNT_W = $clog2(IN + 1);
    localparam int DEPTH    = 1 << ADDR;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t                 head_q, head_d;
    ptr_t                 tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    wr_req_t              mem_q [QDEPTH];
    wr_req_t              mem_d [QDEPTH];

    wr_req_t [IN-1:0]     lane_req;
    wr_req_t [IN-1:0]     packed_req;
    logic [IN_CNT_W-1:0]  packed_cnt;

    logic                 in_ready;
    logic [CNT_W-1:0]     n_enq;
    logic [CNT_W-1:0]     n_drain;
    ptr_t                 wr_ptr;
    ptr_t                 rd_ptr;
    ptr_t                 occ_off;
    logic [DEPTH-1:0]     pend_v;

    always_comb begin
        lane_req = '0;
        for (int i = 0; i < IN; i++) begin
            lane_req[i].addr = bus.in_addr[i][ADDR-1:0];
            lane_req[i].data = bus.in_data[i][DATA-1:0];
        end
    end

    lane_compact #(
        .IN       (IN),
        .ZERO_REG (ZERO_REG)
    ) u_compact (
        .in_valid (bus.in_valid),
        .in_req   (lane_req),
        .out_req  (packed_req),
        .out_cnt  (packed_cnt)
    );

    // Free space comes from the registered count only, so in_ready never
    // depends on this cycle's drain or on wstall.
    assign in_ready     = (QDEPTH - int'(count_q)) >= IN;
    assign bus.in_ready = in_ready;
    assign n_enq        = in_ready ? CNT_W'(packed_cnt) : '0;

    always_comb begin
        n_drain = '0;
        if (!bus.wstall) begin
            n_drain = (count_q < CNT_W'(WRITE)) ? count_q : CNT_W'(WRITE);
        end
    end

    // Drain mux: port p carries entry head+p; idle ports are zeroed.
    always_comb begin
        bus.we_   = {WRITE{WE_IDLE}};
        bus.waddr = '0;
        bus.wdata = '0;
        rd_ptr    = head_q;
        for (int p = 0; p < WRITE; p++) begin
            rd_ptr = head_q + PTR_W'(p);
            if (CNT_W'(p) < n_drain) begin
                bus.we_[p]   = WE_ACTIVE;
                bus.waddr[p] = mem_q[rd_ptr].addr;
                bus.wdata[p] = mem_q[rd_ptr].data;
            end
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wr_ptr = tail_q;
        for (int i = 0; i < IN; i++) begin
            wr_ptr = tail_q + PTR_W'(i);
            if (in_ready && (IN_CNT_W'(i) < packed_cnt)) begin
                mem_d[wr_ptr] = packed_req[i];
            end
        end
        tail_d  = in_ready ? (tail_q + PTR_W'(packed_cnt)) : tail_q;
        head_d  = head_q + PTR_W'(n_drain);
        count_d = count_q + n_enq - n_drain;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // An entry is occupied when its distance from head is below count.
    always_comb begin
        pend_v  = '0;
        occ_off = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            occ_off = PTR_W'(i) - head_q;
            if (CNT_W'(occ_off) < count_q) begin
                pend_v = pend_v | onehot_decode(mem_q[i].addr);
            end
        end
    end

    assign bus.pend  = pend_v;
    assign bus.count = count_q;

endmodule

// File: tb/tb_regfile_wr_seq.sv
module tb_regfile_wr_seq;
    import regfile_pkg::*;

    localparam int DATA   = 32;
    localparam int ADDR   = 4;
    localparam int IN     = 4;
    localparam int WRITE  = 2;
    localparam int QDEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wr_seq_if #(.DATA(DATA), .ADDR(ADDR), .IN(IN), .WRITE(WRITE), .QDEPTH(QDEPTH)) b ();
    regfile_wr_seq_if #(.DATA(DATA), .ADDR(ADDR), .IN(IN), .WRITE(WRITE), .QDEPTH(QDEPTH)) bz ();

    regfile_wr_seq #(.DATA(DATA), .ADDR(ADDR), .IN(IN), .WRITE(WRITE), .QDEPTH(QDEPTH),
                     .ZERO_REG(1'b0)) dut (.clk(clk), .reset(reset), .bus(b));
    regfile_wr_seq #(.DATA(DATA), .ADDR(ADDR), .IN(IN), .WRITE(WRITE), .QDEPTH(QDEPTH),
                     .ZERO_REG(1'b1)) dut_z (.clk(clk), .reset(reset), .bus(bz));

    int tests = 0;
    int fails = 0;

    // Scoreboard: entries the DUT should be holding, oldest first.
    wr_req_t mq [$];
    wr_req_t acc_q [$];
    int      drain_n;

    // Register-file model fed by the write ports; highest port wins.
    logic [DATA-1:0] rf [1 << ADDR];
    always @(posedge clk) begin
        for (int p = 0; p < WRITE; p++) begin
            if (b.we_[p] === 1'b0) rf[b.waddr[p]] <= b.wdata[p];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [15:0] model_pend();
        logic [15:0] v;
        v = '0;
        foreach (mq[i]) v[mq[i].addr] = 1'b1;
        return v;
    endfunction

    // At the falling edge: compare every output against the scoreboard and
    // record what the next rising edge drains and accepts.
    task automatic cyc(input string tag);
        int  n;
        logic rdy;
        @(negedge clk);
        n   = b.wstall ? 0 : ((mq.size() < WRITE) ? mq.size() : WRITE);
        rdy = (QDEPTH - mq.size()) >= IN;
        chk({tag, ".count"}, b.count, mq.size());
        chk({tag, ".in_ready"}, b.in_ready, rdy);
        chk({tag, ".pend"}, b.pend, model_pend());
        for (int p = 0; p < WRITE; p++) begin
            if (p < n) begin
                chk({tag, ".we_"}, b.we_[p], 1'b0);
                chk({tag, ".waddr"}, b.waddr[p], mq[p].addr);
                chk({tag, ".wdata"}, b.wdata[p], mq[p].data);
            end else begin
                chk({tag, ".we_idle"}, b.we_[p], 1'b1);
                chk({tag, ".waddr_idle"}, b.waddr[p], 0);
                chk({tag, ".wdata_idle"}, b.wdata[p], 0);
            end
        end
        drain_n = n;
        acc_q.delete();
        if (rdy) begin
            for (int i = 0; i < IN; i++) begin
                if (b.in_valid[i]) acc_q.push_back('{addr: b.in_addr[i], data: b.in_data[i]});
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        repeat (drain_n) void'(mq.pop_front());
        foreach (acc_q[i]) mq.push_back(acc_q[i]);
    endtask

    task automatic tick(input string tag);
        cyc(tag);
        adv();
    endtask

    task automatic lanes_clear();
        b.in_valid = '0;
        b.in_addr  = '0;
        b.in_data  = '0;
    endtask

    task automatic lane(input int i, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        b.in_valid[i] = 1'b1;
        b.in_addr[i]  = a;
        b.in_data[i]  = d;
    endtask

    initial begin
        reset     = 1'b1;
        b.wstall  = 1'b0;
        lanes_clear();
        bz.wstall   = 1'b0;
        bz.in_valid = '0;
        bz.in_addr  = '0;
        bz.in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.count", b.count, 0);
        chk("rst.we_", b.we_, 2'b11);
        chk("rst.waddr", b.waddr, 0);
        chk("rst.wdata", b.wdata, 0);
        chk("rst.pend", b.pend, 0);
        chk("rst.in_ready", b.in_ready, 1);
        @(posedge clk);
        #1;
        tick("idle");

        // Single write
        lane(0, 4'd3, 32'hA5A5_A5A5);
        tick("single.enq");
        lanes_clear();
        cyc("single.drain");
        chk("single.we_", b.we_, 2'b10);
        chk("single.waddr0", b.waddr[0], 3);
        chk("single.wdata0", b.wdata[0], 32'hA5A5_A5A5);
        chk("single.pend3", b.pend[3], 1);
        adv();
        cyc("single.after");
        chk("single.pend3_clr", b.pend[3], 0);
        adv();

        // Ordering, with an invalid lane compacted out
        lane(0, 4'd5, 32'd1);
        lane(2, 4'd5, 32'd2);
        lane(3, 4'd7, 32'd3);
        tick("order.enq");
        lanes_clear();
        cyc("order.d0");
        chk("order.we_0", b.we_, 2'b00);
        chk("order.p0", {b.waddr[0], b.wdata[0]}, {4'd5, 32'd1});
        chk("order.p1", {b.waddr[1], b.wdata[1]}, {4'd5, 32'd2});
        adv();
        cyc("order.d1");
        chk("order.we_1", b.we_, 2'b10);
        chk("order.p0b", {b.waddr[0], b.wdata[0]}, {4'd7, 32'd3});
        adv();
        chk("order.reg5", rf[5], 2);
        chk("order.reg7", rf[7], 3);

        // Full and wrap
        b.wstall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < IN; i++) lane(i, 4'(k * 4 + i + 1), 32'hC0DE_0000 + 32'(k * 16 + i));
            tick("full.enq");
        end
        cyc("full.blocked");
        chk("full.in_ready", b.in_ready, 0);
        chk("full.count", b.count, 8);
        chk("full.we_", b.we_, 2'b11);
        adv();
        lanes_clear();
        b.wstall = 1'b0;
        repeat (4) tick("wrap.drain");
        cyc("wrap.empty");
        chk("wrap.count", b.count, 0);
        chk("wrap.we_", b.we_, 2'b11);
        adv();

        // Simultaneous enqueue and drain
        b.wstall = 1'b1;
        lane(0, 4'd1, 32'h51);
        lane(1, 4'd2, 32'h52);
        lane(2, 4'd3, 32'h53);
        tick("simul.load");
        lanes_clear();
        b.wstall = 1'b0;
        for (int i = 0; i < IN; i++) lane(i, 4'(9 + i), 32'h60 + 32'(i));
        cyc("simul.both");
        chk("simul.count3", b.count, 3);
        chk("simul.ready1", b.in_ready, 1);
        adv();
        lanes_clear();
        cyc("simul.next");
        chk("simul.count5", b.count, 5);
        chk("simul.ready0", b.in_ready, 0);
        adv();
        repeat (3) tick("simul.drain");

        // Reset mid-burst
        b.wstall = 1'b1;
        for (int i = 0; i < IN; i++) lane(i, 4'(i + 4), 32'h70 + 32'(i));
        tick("rstmid.l0");
        lanes_clear();
        lane(0, 4'd12, 32'h7F);
        tick("rstmid.l1");
        lanes_clear();
        cyc("rstmid.loaded");
        chk("rstmid.count5", b.count, 5);
        adv();
        b.wstall = 1'b0;
        #1;
        chk("rstmid.pre_we_", b.we_, 2'b00);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid.count", b.count, 0);
        chk("rstmid.pend", b.pend, 0);
        chk("rstmid.we_", b.we_, 2'b11);
        chk("rstmid.in_ready", b.in_ready, 1);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tick("rstmid.idle");

        // Zero register dropped at enqueue
        bz.wstall      = 1'b1;
        bz.in_valid[0] = 1'b1;
        bz.in_addr[0]  = 4'd0;
        bz.in_data[0]  = 32'h11;
        bz.in_valid[1] = 1'b1;
        bz.in_addr[1]  = 4'd2;
        bz.in_data[1]  = 32'h22;
        @(negedge clk);
        chk("zero.ready", bz.in_ready, 1);
        @(posedge clk);
        #1;
        bz.in_valid = '0;
        chk("zero.count", bz.count, 1);
        chk("zero.pend0", bz.pend[0], 0);
        chk("zero.pend", bz.pend, 16'h0004);
        bz.wstall = 1'b0;
        @(negedge clk);
        chk("zero.we_", bz.we_, 2'b10);
        chk("zero.p0", {bz.waddr[0], bz.wdata[0]}, {4'd2, 32'h22});
        @(posedge clk);
        #1;
        chk("zero.count_end", bz.count, 0);
        chk("zero.pend_end", bz.pend, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
